vram_arbiter: RTL and testbench

Shares one single-port, synchronous-read framebuffer RAM between CPU load/store accesses and the VGA scanout path. Per scanline it prefetches pixel words into a small FIFO. CPU accesses run in the remaining slots and stall the CPU via a ready handshake. It sits between the CPU memory bus, the VGA timing generator and the RAM, replacing the current dual-port video read.

---
 rtl/vram_pkg.sv | 12 +
 rtl/vram_line_fifo.sv | 62 ++++++
 rtl/vram_arbiter.sv | 159 +++++++++++++++
 tb/tb_vram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types for the framebuffer RAM arbiter: slot-owner state and word/mask widths.
package vram_pkg;
  localparam int WORD_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    VGA_RD,
    CPU_WR,
    CPU_RD
  } state_e;
endpackage

// File: rtl/vram_line_fifo.sv
// Scanout line FIFO: single-clock FIFO with flush; the head word is presented combinationally.
module vram_line_fifo
  import vram_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop && !flush);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-only; occupancy tracking alone decides which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/vram_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA line prefetch into a FIFO plus stalled CPU accesses.
// Optional macro VRAM_STARVE_EN bounds CPU waiting to STARVE_MAX cycles even against urgent VGA.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  input  logic [MASK_W-1:0] cpu_wmask,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              vga_line_start,
  input  logic [ADDR_W-1:0] vga_line_base,
  input  logic [7:0]        vga_line_words,
  input  logic              vga_pop,
  output logic [WORD_W-1:0] vga_data,
  output logic              vga_empty,
  output logic              vga_underrun,
  output logic              ram_en,
  output logic [MASK_W-1:0] ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W  = CNT_W + 1;
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);
`ifdef VRAM_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        rem_q, rem_d;
  logic              vga_pend_q, vga_pend_d;
  logic              rd_done_q, rd_done_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              underrun_q, underrun_d;
  logic [MASK_W-1:0] ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [OCC_W-1:0]  occ;
  logic              vga_need, vga_urgent, cpu_free, starve;
  logic              cpu_grant, vga_grant;

  vram_line_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (vga_line_start),
    .push      (vga_pend_q),
    .push_data (ram_rdata),
    .pop       (vga_pop),
    .head      (vga_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Words already committed to the FIFO: stored, issued this cycle, or returning this cycle.
  always_comb begin
    occ        = OCC_W'(fifo_count) + OCC_W'(state_q == VGA_RD) + OCC_W'(vga_pend_q);
    vga_need   = (rem_q != '0) && (occ < OCC_W'(FIFO_DEPTH)) && !vga_line_start;
    vga_urgent = vga_need && (occ < OCC_W'(FIFO_DEPTH / 2));
    cpu_free   = cpu_req && (state_q != CPU_WR) && (state_q != CPU_RD) && !rd_done_q;
    starve     = STARVE_ON && (wait_q >= WAIT_W'(STARVE_MAX));
  end

  always_comb begin
    state_d     = IDLE;
    cpu_grant   = 1'b0;
    vga_grant   = 1'b0;
    ram_we_d    = '0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    wait_d      = wait_q;

    if (cpu_free && starve)  cpu_grant = 1'b1;
    else if (vga_urgent)     vga_grant = 1'b1;
    else if (cpu_free)       cpu_grant = 1'b1;
    else if (vga_need)       vga_grant = 1'b1;

    if (cpu_grant) begin
      state_d     = cpu_we ? CPU_WR : CPU_RD;
      ram_we_d    = cpu_we ? cpu_wmask : '0;
      ram_addr_d  = cpu_addr;
      ram_wdata_d = cpu_we ? cpu_wdata : '0;
    end else if (vga_grant) begin
      state_d    = VGA_RD;
      ram_addr_d = ptr_q;
      ptr_d      = ptr_q + 1'b1;
      rem_d      = rem_q - 8'd1;
    end

    if (vga_line_start) begin
      ptr_d = vga_line_base;
      rem_d = vga_line_words;
    end

    if (cpu_grant)                                        wait_d = '0;
    else if (cpu_free && (wait_q < WAIT_W'(STARVE_MAX)))  wait_d = wait_q + 1'b1;

    // A line start drops both the read being issued and the word returning now.
    vga_pend_d = (state_q == VGA_RD) && !vga_line_start;
    rd_done_d  = (state_q == CPU_RD);
    rdata_d    = rd_done_q ? ram_rdata : rdata_q;
    underrun_d = underrun_q || (vga_pop && fifo_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      vga_pend_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      rdata_q     <= '0;
      underrun_q  <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      vga_pend_q  <= vga_pend_d;
      rd_done_q   <= rd_done_d;
      rdata_q     <= rdata_d;
      underrun_q  <= underrun_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      wait_q      <= wait_d;
    end
  end

  assign ram_en       = (state_q != IDLE);
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign cpu_ready    = (state_q == CPU_WR) || rd_done_q;
  assign cpu_rdata    = rd_done_q ? ram_rdata : rdata_q;
  assign vga_empty    = fifo_empty;
  assign vga_underrun = underrun_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous-read RAM (unwritten word a reads as a).
module tb_vram_arbiter;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [3:0]        cpu_wmask = '0;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              vga_line_start = 1'b0;
  logic [ADDR_W-1:0] vga_line_base = '0;
  logic [7:0]        vga_line_words = '0;
  logic              vga_pop = 1'b0;
  logic [31:0]       vga_data;
  logic              vga_empty;
  logic              vga_underrun;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;

  int checks = 0;
  int failures = 0;

  vram_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(8), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wmask(cpu_wmask), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .vga_line_start(vga_line_start), .vga_line_base(vga_line_base),
    .vga_line_words(vga_line_words), .vga_pop(vga_pop), .vga_data(vga_data),
    .vga_empty(vga_empty), .vga_underrun(vga_underrun),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model
  logic [31:0] mem [int];
  logic [31:0] wword;

  function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {18'd0, a};
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we != 4'h0) begin
        wword = rd_word(ram_addr);
        for (int b = 0; b < 4; b++) if (ram_we[b]) wword[8*b +: 8] = ram_wdata[8*b +: 8];
        mem[int'(ram_addr)] = wword;
      end else begin
        ram_rdata <= rd_word(ram_addr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [ADDR_W-1:0] base, input logic [7:0] words);
    vga_line_start = 1'b1;
    vga_line_base  = base;
    vga_line_words = words;
    step();
    vga_line_start = 1'b0;
  endtask

  task automatic cpu_xfer(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] m, output logic [31:0] rd, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wmask = m;
    lat = 0;
    do begin
      step();
      lat++;
    end while (cpu_ready !== 1'b1 && lat < 100);
    rd = cpu_rdata;
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_wmask = 4'hF; vga_pop = 1'b1;
    step(); step();
    checks++; if (ram_en !== 1'b0 || ram_we !== 4'h0 || ram_addr !== '0 || ram_wdata !== '0)
      begin failures++; $display("FAIL reset_ram: got en=%b we=%h addr=%h wd=%h expected all 0", ram_en, ram_we, ram_addr, ram_wdata); end
    checks++; if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0)
      begin failures++; $display("FAIL reset_cpu: got ready=%b rdata=%h expected 0 0", cpu_ready, cpu_rdata); end
    checks++; if (vga_empty !== 1'b1 || vga_underrun !== 1'b0 || vga_data !== 32'h0)
      begin failures++; $display("FAIL reset_vga: got empty=%b underrun=%b data=%h expected 1 0 0", vga_empty, vga_underrun, vga_data); end
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_wmask = 4'h0; vga_pop = 1'b0;
    reset = 1'b0;
    step();
    checks++; if (ram_en !== 1'b0 || vga_underrun !== 1'b0)
      begin failures++; $display("FAIL reset_release: got en=%b underrun=%b expected 0 0", ram_en, vga_underrun); end
  endtask

  task automatic test_line_fetch();
    logic [ADDR_W-1:0] ea;
    start_line(14'h100, 8'd4);
    checks++; if (ram_en !== 1'b0)
      begin failures++; $display("FAIL fetch_first_idle: got en=%b expected 0", ram_en); end
    for (int i = 0; i < 4; i++) begin
      step();
      ea = 14'h100 + 14'(i);
      checks++; if (ram_en !== 1'b1 || ram_we !== 4'h0 || ram_addr !== ea)
        begin failures++; $display("FAIL fetch_addr%0d: got en=%b we=%h addr=%h expected 1 0 %h", i, ram_en, ram_we, ram_addr, ea); end
      if (i == 1) begin
        checks++; if (vga_empty !== 1'b1)
          begin failures++; $display("FAIL fetch_empty_early: got %b expected 1", vga_empty); end
      end
      if (i == 2) begin
        checks++; if (vga_empty !== 1'b0 || vga_data !== 32'h100)
          begin failures++; $display("FAIL fetch_first_word: got empty=%b data=%h expected 0 100", vga_empty, vga_data); end
      end
    end
    step();
    checks++; if (ram_en !== 1'b0)
      begin failures++; $display("FAIL fetch_stop: got en=%b expected 0", ram_en); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (vga_empty !== 1'b0 || vga_data !== 32'h100 + 32'(i))
        begin failures++; $display("FAIL fetch_fifo%0d: got empty=%b data=%h expected 0 %h", i, vga_empty, vga_data, 32'h100 + 32'(i)); end
      vga_pop = 1'b1;
      step();
      vga_pop = 1'b0;
    end
    checks++; if (vga_empty !== 1'b1 || vga_underrun !== 1'b0)
      begin failures++; $display("FAIL fetch_drained: got empty=%b underrun=%b expected 1 0", vga_empty, vga_underrun); end
  endtask

  task automatic test_cpu_write_read();
    logic [31:0] rd;
    int lat;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h020; cpu_wdata = 32'hDEADBEEF; cpu_wmask = 4'hF;
    step();
    checks++; if (ram_en !== 1'b1 || ram_we !== 4'hF || ram_addr !== 14'h020 || ram_wdata !== 32'hDEADBEEF || cpu_ready !== 1'b1)
      begin failures++; $display("FAIL wr_issue: got en=%b we=%h addr=%h wd=%h ready=%b expected 1 f 020 deadbeef 1", ram_en, ram_we, ram_addr, ram_wdata, cpu_ready); end
    cpu_we = 1'b0;
    step();
    checks++; if (ram_en !== 1'b0 || cpu_ready !== 1'b0)
      begin failures++; $display("FAIL b2b_gap: got en=%b ready=%b expected 0 0", ram_en, cpu_ready); end
    step();
    checks++; if (ram_en !== 1'b1 || ram_we !== 4'h0 || ram_addr !== 14'h020 || cpu_ready !== 1'b0)
      begin failures++; $display("FAIL rd_issue: got en=%b we=%h addr=%h ready=%b expected 1 0 020 0", ram_en, ram_we, ram_addr, cpu_ready); end
    step();
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hDEADBEEF)
      begin failures++; $display("FAIL rd_done: got ready=%b rdata=%h expected 1 deadbeef", cpu_ready, cpu_rdata); end
    cpu_req = 1'b0;
    step();
    checks++; if (cpu_ready !== 1'b0 || cpu_rdata !== 32'hDEADBEEF)
      begin failures++; $display("FAIL rd_hold: got ready=%b rdata=%h expected 0 deadbeef", cpu_ready, cpu_rdata); end
    cpu_xfer(1'b1, 14'h020, 32'h12345678, 4'h0, rd, lat);
    checks++; if (lat !== 1)
      begin failures++; $display("FAIL wr_mask0_lat: got %0d expected 1", lat); end
    cpu_xfer(1'b1, 14'h020, 32'h11223344, 4'h3, rd, lat);
    checks++; if (lat !== 1)
      begin failures++; $display("FAIL wr_mask3_lat: got %0d expected 1", lat); end
    cpu_xfer(1'b0, 14'h020, 32'h0, 4'h0, rd, lat);
    checks++; if (lat !== 2 || rd !== 32'hDEAD3344)
      begin failures++; $display("FAIL rd_masked: got lat=%0d rdata=%h expected 2 dead3344", lat, rd); end
  endtask

  task automatic test_cpu_vs_fetch();
    logic [ADDR_W-1:0] ea;
    int idx;
    start_line(14'h200, 8'd16);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h020;
    for (int i = 0; i < 4; i++) begin
      step();
      ea = 14'h200 + 14'(i);
      checks++; if (ram_en !== 1'b1 || ram_we !== 4'h0 || ram_addr !== ea || cpu_ready !== 1'b0)
        begin failures++; $display("FAIL urgent_vga%0d: got en=%b addr=%h ready=%b expected 1 %h 0", i, ram_en, ram_addr, cpu_ready, ea); end
    end
    step();
    checks++; if (ram_en !== 1'b1 || ram_we !== 4'h0 || ram_addr !== 14'h020 || cpu_ready !== 1'b0)
      begin failures++; $display("FAIL cpu_grant_occ4: got en=%b addr=%h ready=%b expected 1 020 0", ram_en, ram_addr, cpu_ready); end
    step();
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hDEAD3344)
      begin failures++; $display("FAIL cpu_ready_fetch: got ready=%b rdata=%h expected 1 dead3344", cpu_ready, cpu_rdata); end
    cpu_req = 1'b0;
    idx = 0;
    for (int c = 0; c < 300 && idx < 16; c++) begin
      vga_pop = !vga_empty;
      if (!vga_empty) begin
        checks++; if (vga_data !== 32'h200 + 32'(idx))
          begin failures++; $display("FAIL line16_word%0d: got %h expected %h", idx, vga_data, 32'h200 + 32'(idx)); end
        idx++;
      end
      step();
    end
    vga_pop = 1'b0;
    checks++; if (idx !== 16 || vga_empty !== 1'b1)
      begin failures++; $display("FAIL line16_count: got words=%0d empty=%b expected 16 1", idx, vga_empty); end
  endtask

  task automatic test_underrun();
    checks++; if (vga_underrun !== 1'b0)
      begin failures++; $display("FAIL underrun_pre: got %b expected 0", vga_underrun); end
    vga_pop = 1'b1;
    step();
    vga_pop = 1'b0;
    checks++; if (vga_underrun !== 1'b1 || vga_empty !== 1'b1 || vga_data !== 32'h0)
      begin failures++; $display("FAIL underrun_set: got underrun=%b empty=%b data=%h expected 1 1 0", vga_underrun, vga_empty, vga_data); end
    start_line(14'h300, 8'd2);
    for (int i = 0; i < 6; i++) step();
    checks++; if (vga_underrun !== 1'b1 || vga_empty !== 1'b0 || vga_data !== 32'h300)
      begin failures++; $display("FAIL underrun_sticky: got underrun=%b empty=%b data=%h expected 1 0 300", vga_underrun, vga_empty, vga_data); end
    vga_pop = 1'b1;
    step(); step();
    vga_pop = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (vga_underrun !== 1'b0 || vga_empty !== 1'b1)
      begin failures++; $display("FAIL underrun_async_clear: got underrun=%b empty=%b expected 0 1", vga_underrun, vga_empty); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_line_restart();
    logic [ADDR_W-1:0] ea;
    start_line(14'h400, 8'd8);
    step(); step(); step();
    checks++; if (ram_addr !== 14'h402 || vga_empty !== 1'b0)
      begin failures++; $display("FAIL restart_setup: got addr=%h empty=%b expected 402 0", ram_addr, vga_empty); end
    start_line(14'h500, 8'd3);
    checks++; if (vga_empty !== 1'b1 || ram_en !== 1'b0)
      begin failures++; $display("FAIL restart_flush: got empty=%b en=%b expected 1 0", vga_empty, ram_en); end
    for (int i = 0; i < 3; i++) begin
      step();
      ea = 14'h500 + 14'(i);
      checks++; if (ram_en !== 1'b1 || ram_addr !== ea)
        begin failures++; $display("FAIL restart_addr%0d: got en=%b addr=%h expected 1 %h", i, ram_en, ram_addr, ea); end
    end
    step();
    checks++; if (ram_en !== 1'b0)
      begin failures++; $display("FAIL restart_stop: got en=%b expected 0", ram_en); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (vga_empty !== 1'b0 || vga_data !== 32'h500 + 32'(i))
        begin failures++; $display("FAIL restart_word%0d: got empty=%b data=%h expected 0 %h", i, vga_empty, vga_data, 32'h500 + 32'(i)); end
      vga_pop = 1'b1;
      step();
      vga_pop = 1'b0;
    end
    checks++; if (vga_empty !== 1'b1 || vga_underrun !== 1'b0)
      begin failures++; $display("FAIL restart_drained: got empty=%b underrun=%b expected 1 0", vga_empty, vga_underrun); end
  endtask

  task automatic test_urgent_starve();
    int issue_at, ready_at, pops;
    logic [31:0] rd;
    issue_at = -1; ready_at = -1; pops = 0; rd = '0;
    start_line(14'h600, 8'd40);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h020;
    for (int k = 1; k <= 120; k++) begin
      vga_pop = !vga_empty;
      if (!vga_empty) pops++;
      step();
      if (ram_en === 1'b1 && ram_we === 4'h0 && ram_addr === 14'h020 && issue_at < 0) issue_at = k;
      if (cpu_ready === 1'b1 && ready_at < 0) begin
        ready_at = k;
        rd = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    vga_pop = 1'b0;
`ifdef VRAM_STARVE_EN
    checks++; if (issue_at !== 4 || ready_at !== 5)
      begin failures++; $display("FAIL starve_grant: got issue=%0d ready=%0d expected 4 5", issue_at, ready_at); end
`else
    checks++; if (issue_at !== 41 || ready_at !== 42)
      begin failures++; $display("FAIL strict_grant: got issue=%0d ready=%0d expected 41 42", issue_at, ready_at); end
`endif
    checks++; if (rd !== 32'hDEAD3344)
      begin failures++; $display("FAIL urgent_rdata: got %h expected dead3344", rd); end
    checks++; if (pops !== 40 || vga_empty !== 1'b1 || vga_underrun !== 1'b0)
      begin failures++; $display("FAIL urgent_pops: got pops=%0d empty=%b underrun=%b expected 40 1 0", pops, vga_empty, vga_underrun); end
  endtask

  task automatic test_reset_abort();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h020;
    step();
    checks++; if (ram_en !== 1'b1 || ram_addr !== 14'h020)
      begin failures++; $display("FAIL abort_issue: got en=%b addr=%h expected 1 020", ram_en, ram_addr); end
    reset = 1'b1;
    #1;
    checks++; if (ram_en !== 1'b0 || cpu_ready !== 1'b0 || cpu_rdata !== 32'h0)
      begin failures++; $display("FAIL abort_async: got en=%b ready=%b rdata=%h expected 0 0 0", ram_en, cpu_ready, cpu_rdata); end
    cpu_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++; if (cpu_ready !== 1'b0 || ram_en !== 1'b0)
      begin failures++; $display("FAIL abort_no_ready: got ready=%b en=%b expected 0 0", cpu_ready, ram_en); end
    step();
    checks++; if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0)
      begin failures++; $display("FAIL abort_quiet: got ready=%b rdata=%h expected 0 0", cpu_ready, cpu_rdata); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    test_reset();
    test_line_fetch();
    test_cpu_write_read();
    test_cpu_vs_fetch();
    test_underrun();
    test_line_restart();
    test_urgent_starve();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
